// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multi-cycle MIPS control unit with memory handshake, traps and counters
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   opcode, funcode   IR[31:26] and IR[5:0]
//   equal             ALU zero flag (drives pcEn in BRANCH)
//   memAck            memory completed the current request this cycle
//   memReq..signExtSignal  datapath strobes and mux selects
//   busErr, illegalOp sticky trap flags (memory timeout, unsupported instruction)
//   cycleCnt, instRet cycles since reset and retired instructions, CNT_W bits, wrapping
module mc_control_fsm #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funcode,
    input  logic             equal,
    input  logic             memAck,
    output logic             memReq,
    output logic             memWrite,
    output logic             iorD,
    output logic             irWrite,
    output logic             pcEn,
    output logic [1:0]       pcSrc,
    output logic             regWrite,
    output logic             waControl,
    output logic             wdControl,
    output logic             aluSrcA,
    output logic [1:0]       aluSrcB,
    output logic [2:0]       aluControl,
    output logic             signExtSignal,
    output logic             busErr,
    output logic             illegalOp,
    output logic [CNT_W-1:0] cycleCnt,
    output logic [CNT_W-1:0] instRet
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam int         WAIT_W   = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_IMMEX, S_IMMWB, S_MEMADDR,
        S_MEMREAD, S_MEMWB, S_MEMWR, S_BRANCH, S_JUMP, S_ERROR
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WAIT_W-1:0]  r_wait;
    logic [CNT_W-1:0]   r_cycle_cnt;
    logic [CNT_W-1:0]   r_inst_ret;
    logic               r_bus_err;
    logic               r_illegal_op;
    logic               w_mem_state;
    logic               w_timeout;
    logic               w_funct_ok;
    logic               w_op_illegal;
    logic               w_retire;
    logic [2:0]         w_funct_alu;

    always_comb begin
        w_funct_ok  = 1'b1;
        w_funct_alu = 3'b000;
        case (funcode)
            6'h20:   w_funct_alu = 3'b000;
            6'h22:   w_funct_alu = 3'b001;
            6'h24:   w_funct_alu = 3'b010;
            6'h25:   w_funct_alu = 3'b011;
            6'h2A:   w_funct_alu = 3'b100;
            default: w_funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        case (opcode)
            OP_RTYPE:                                     w_op_illegal = !w_funct_ok;
            OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ORI:  w_op_illegal = 1'b0;
            default:                                      w_op_illegal = 1'b1;
        endcase
    end

    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWR);
    // r_wait holds the number of cycles already spent waiting, so the
    // TIMEOUT-th request cycle sees TIMEOUT-1; an ack on that cycle still wins.
    assign w_timeout   = w_mem_state && !memAck && (r_wait == WAIT_W'(TIMEOUT - 1));
    assign w_retire    = (r_state == S_ALUWB) || (r_state == S_IMMWB) || (r_state == S_MEMWB) ||
                         (r_state == S_BRANCH) || (r_state == S_JUMP) ||
                         ((r_state == S_MEMWR) && memAck);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:   w_next = memAck ? S_DECODE : (w_timeout ? S_ERROR : S_FETCH);
            S_DECODE: begin
                if (w_op_illegal) begin
                    w_next = S_ERROR;
                end else begin
                    case (opcode)
                        OP_RTYPE:       w_next = S_EXEC;
                        OP_LW, OP_SW:   w_next = S_MEMADDR;
                        OP_BEQ:         w_next = S_BRANCH;
                        OP_J:           w_next = S_JUMP;
                        default:        w_next = S_IMMEX;
                    endcase
                end
            end
            S_EXEC:    w_next = S_ALUWB;
            S_IMMEX:   w_next = S_IMMWB;
            S_MEMADDR: w_next = (opcode == OP_SW) ? S_MEMWR : S_MEMREAD;
            S_MEMREAD: w_next = memAck ? S_MEMWB : (w_timeout ? S_ERROR : S_MEMREAD);
            S_MEMWR:   w_next = memAck ? S_FETCH : (w_timeout ? S_ERROR : S_MEMWR);
            S_ERROR:   w_next = S_ERROR;
            default:   w_next = S_FETCH;
        endcase
    end

    always_comb begin
        memReq        = 1'b0;
        memWrite      = 1'b0;
        iorD          = 1'b0;
        irWrite       = 1'b0;
        pcEn          = 1'b0;
        pcSrc         = 2'b00;
        regWrite      = 1'b0;
        waControl     = 1'b0;
        wdControl     = 1'b0;
        aluSrcA       = 1'b0;
        aluSrcB       = 2'b00;
        aluControl    = 3'b000;
        signExtSignal = 1'b0;
        // Strobes are gated by rst so the datapath sees nothing while in reset.
        if (rst) begin
            case (r_state)
                S_FETCH: begin
                    memReq  = 1'b1;
                    aluSrcB = 2'b01;
                    irWrite = memAck;
                    pcEn    = memAck;
                end
                S_DECODE: begin
                    aluSrcB       = 2'b11;
                    signExtSignal = 1'b1;
                end
                S_EXEC: begin
                    aluSrcA    = 1'b1;
                    aluControl = w_funct_alu;
                end
                S_ALUWB: begin
                    regWrite  = 1'b1;
                    waControl = 1'b1;
                end
                S_IMMEX: begin
                    aluSrcA = 1'b1;
                    aluSrcB = 2'b10;
                    if (opcode == OP_ORI) begin
                        aluControl = 3'b011;
                    end else begin
                        signExtSignal = 1'b1;
                    end
                end
                S_IMMWB:   regWrite = 1'b1;
                S_MEMADDR: begin
                    aluSrcA       = 1'b1;
                    aluSrcB       = 2'b10;
                    signExtSignal = 1'b1;
                end
                S_MEMREAD: begin
                    memReq = 1'b1;
                    iorD   = 1'b1;
                end
                S_MEMWB: begin
                    regWrite  = 1'b1;
                    wdControl = 1'b1;
                end
                S_MEMWR: begin
                    memReq   = 1'b1;
                    memWrite = 1'b1;
                    iorD     = 1'b1;
                end
                S_BRANCH: begin
                    aluSrcA    = 1'b1;
                    aluControl = 3'b001;
                    pcSrc      = 2'b01;
                    pcEn       = equal;
                end
                S_JUMP: begin
                    pcSrc = 2'b10;
                    pcEn  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait       <= '0;
            r_cycle_cnt  <= '0;
            r_inst_ret   <= '0;
            r_bus_err    <= 1'b0;
            r_illegal_op <= 1'b0;
        end else begin
            // Any state change restarts the wait count, so each new request starts at zero.
            if (w_next != r_state) begin
                r_wait <= '0;
            end else if (w_mem_state) begin
                r_wait <= r_wait + 1'b1;
            end
            if (r_state != S_ERROR) begin
                r_cycle_cnt <= r_cycle_cnt + 1'b1;
            end
            if (w_retire) begin
                r_inst_ret <= r_inst_ret + 1'b1;
            end
            if (w_timeout) begin
                r_bus_err <= 1'b1;
            end
            if ((r_state == S_DECODE) && w_op_illegal) begin
                r_illegal_op <= 1'b1;
            end
        end
    end

    assign busErr    = r_bus_err;
    assign illegalOp = r_illegal_op;
    assign cycleCnt  = r_cycle_cnt;
    assign instRet   = r_inst_ret;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - randomized self-checking bench for mc_control_fsm
module tb_mc_control_fsm;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic [5:0]  opcode = '0, funcode = '0;
    logic        equal = 1'b0, memAck = 1'b0;
    logic        memReq, memWrite, iorD, irWrite, pcEn, regWrite, waControl, wdControl, aluSrcA;
    logic        signExtSignal, busErr, illegalOp;
    logic [1:0]  pcSrc, aluSrcB;
    logic [2:0]  aluControl;
    logic [31:0] cycleCnt, instRet;

    mc_control_fsm #(.CNT_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funcode(funcode), .equal(equal), .memAck(memAck),
        .memReq(memReq), .memWrite(memWrite), .iorD(iorD), .irWrite(irWrite), .pcEn(pcEn),
        .pcSrc(pcSrc), .regWrite(regWrite), .waControl(waControl), .wdControl(wdControl),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluControl(aluControl), .signExtSignal(signExtSignal),
        .busErr(busErr), .illegalOp(illegalOp), .cycleCnt(cycleCnt), .instRet(instRet)
    );

    logic        rst4 = 1'b0;
    logic [5:0]  opcode4 = 6'h04, funcode4 = 6'h00;
    logic        equal4 = 1'b0, memAck4 = 1'b1;
    logic        memReq4, memWrite4, iorD4, irWrite4, pcEn4, regWrite4, waControl4, wdControl4, aluSrcA4;
    logic        signExtSignal4, busErr4, illegalOp4;
    logic [1:0]  pcSrc4, aluSrcB4;
    logic [2:0]  aluControl4;
    logic [3:0]  cycleCnt4, instRet4;

    mc_control_fsm #(.CNT_W(4), .TIMEOUT(16)) dut4 (
        .clk(clk), .rst(rst4), .opcode(opcode4), .funcode(funcode4), .equal(equal4), .memAck(memAck4),
        .memReq(memReq4), .memWrite(memWrite4), .iorD(iorD4), .irWrite(irWrite4), .pcEn(pcEn4),
        .pcSrc(pcSrc4), .regWrite(regWrite4), .waControl(waControl4), .wdControl(wdControl4),
        .aluSrcA(aluSrcA4), .aluSrcB(aluSrcB4), .aluControl(aluControl4), .signExtSignal(signExtSignal4),
        .busErr(busErr4), .illegalOp(illegalOp4), .cycleCnt(cycleCnt4), .instRet(instRet4)
    );

    logic [16:0] strobes, strobes4;
    assign strobes  = {memReq, memWrite, iorD, irWrite, pcEn, pcSrc, regWrite, waControl, wdControl,
                       aluSrcA, aluSrcB, aluControl, signExtSignal};
    assign strobes4 = {memReq4, memWrite4, iorD4, irWrite4, pcEn4, pcSrc4, regWrite4, waControl4, wdControl4,
                       aluSrcA4, aluSrcB4, aluControl4, signExtSignal4};

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned m_cyc = 0;
    int unsigned m_ret = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'h22:   return 3'b001;
            6'h24:   return 3'b010;
            6'h25:   return 3'b011;
            6'h2A:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Reset is asserted away from any clock edge and released just after a rising edge,
    // so the remainder of that clock period is the first FETCH cycle.
    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        memAck = 1'b0;
        #1;
        check_val("reset_strobes", strobes, 17'd0);
        check_val("reset_counters", cycleCnt | instRet, 32'd0);
        check_val("reset_flags", {busErr, illegalOp}, 2'b00);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        m_cyc = 0;
        m_ret = 0;
    endtask

    // One legal instruction; dF/dD are the ack wait cycles for fetch and data access.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic eq,
                             input int dF, input int dD);
        bit is_r   = (op == 6'h00);
        bit is_lw  = (op == 6'h23);
        bit is_sw  = (op == 6'h2B);
        bit is_imm = (op == 6'h08) || (op == 6'h0D);
        bit is_beq = (op == 6'h04);
        bit is_j   = (op == 6'h02);
        int base, n, req_idx, req_wait, rw_cnt, req_cnt, mw_cnt, ir_cnt, pc_cnt;
        base = (is_lw) ? 5 : ((is_beq || is_j) ? 3 : 4);
        n = base + dF + ((is_lw || is_sw) ? dD : 0);
        req_idx = 0; req_wait = 0; rw_cnt = 0; req_cnt = 0; mw_cnt = 0; ir_cnt = 0; pc_cnt = 0;
        opcode = op; funcode = fn; equal = eq;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (memReq) memAck = (req_wait == ((req_idx == 0) ? dF : dD));
            else        memAck = 1'($urandom_range(0, 1));
            #1;
            if (c == 0) begin
                check_val("start_cycleCnt", cycleCnt, m_cyc);
                check_val("start_instRet", instRet, m_ret);
                check_val("start_fetch", {memReq, iorD, aluSrcB}, {1'b1, 1'b0, 2'b01});
            end
            if (memReq) begin
                req_cnt++;
                if (req_idx == 1) check_val("data_iorD", iorD, 1'b1);
                if (memAck) begin req_idx++; req_wait = 0; end
                else req_wait++;
            end
            if (memWrite) mw_cnt++;
            if (irWrite)  ir_cnt++;
            if (pcEn)     pc_cnt++;
            if (regWrite) begin
                rw_cnt++;
                check_val("wb_cycle", c, n - 1);
                check_val("wb_sel", {waControl, wdControl}, {is_r, is_lw});
            end
            if ((c == dF + 2) && is_r)
                check_val("exec_alu", {aluSrcA, aluSrcB, aluControl}, {1'b1, 2'b00, funct_alu(fn)});
            if ((c == dF + 2) && is_imm)
                check_val("immex_alu", {aluSrcA, aluSrcB, aluControl, signExtSignal},
                          (op == 6'h0D) ? {1'b1, 2'b10, 3'b011, 1'b0} : {1'b1, 2'b10, 3'b000, 1'b1});
            if ((c == n - 1) && is_beq)
                check_val("beq_pc", {pcSrc, pcEn, aluControl}, {2'b01, eq, 3'b001});
            if ((c == n - 1) && is_j)
                check_val("j_pc", {pcSrc, pcEn}, {2'b10, 1'b1});
        end
        check_val("regWrite_count", rw_cnt, (is_r || is_imm || is_lw) ? 1 : 0);
        check_val("memReq_count", req_cnt, dF + 1 + ((is_lw || is_sw) ? dD + 1 : 0));
        check_val("memWrite_count", mw_cnt, is_sw ? dD + 1 : 0);
        check_val("irWrite_count", ir_cnt, 1);
        check_val("pcEn_count", pc_cnt, 1 + ((is_j || (is_beq && eq)) ? 1 : 0));
        m_cyc += n;
        m_ret += 1;
    endtask

    task automatic end_check(input string tag);
        @(negedge clk);
        memAck = 1'b0;
        #1;
        check_val({tag, "_cycleCnt"}, cycleCnt, m_cyc);
        check_val({tag, "_instRet"}, instRet, m_ret);
    endtask

    logic [5:0] ops [7]   = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h0D};
    logic [5:0] fncs [5]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    initial begin
        logic [5:0] op, fn;

        // Directed: R-type add, lw with 3 wait cycles, beq both ways, sw.
        do_reset();
        run_instr(6'h00, 6'h20, 1'b0, 0, 0);
        end_check("radd");
        do_reset();
        run_instr(6'h23, 6'h00, 1'b0, 0, 3);
        run_instr(6'h04, 6'h00, 1'b0, 0, 0);
        run_instr(6'h04, 6'h00, 1'b1, 0, 0);
        run_instr(6'h2B, 6'h00, 1'b0, 1, 2);
        end_check("directed");

        // Random instruction stream with random ack latency.
        do_reset();
        for (int i = 0; i < 60; i++) begin
            op = ops[$urandom_range(0, 6)];
            fn = (op == 6'h00) ? fncs[$urandom_range(0, 4)] : 6'($urandom_range(0, 63));
            run_instr(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
        end
        end_check("random");

        // Fetch never acknowledged: ERROR after 16 request cycles.
        do_reset();
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            memAck = 1'b0;
            #1;
            if (c == 15) check_val("to_req_last", memReq, 1'b1);
        end
        @(negedge clk);
        memAck = 1'b1;
        #1;
        check_val("to_busErr", {busErr, illegalOp}, 2'b10);
        check_val("to_strobes", strobes, 17'd0);
        check_val("to_cycleCnt", cycleCnt, 32'd16);
        repeat (3) @(negedge clk);
        #1;
        check_val("to_frozen", cycleCnt, 32'd16);
        check_val("to_instRet", instRet, 32'd0);

        // Ack on the 16th request cycle completes normally.
        do_reset();
        run_instr(6'h00, 6'h22, 1'b0, 15, 0);
        end_check("ack16");
        check_val("ack16_busErr", busErr, 1'b0);

        // Illegal opcode after one retired instruction, then illegal funct.
        do_reset();
        run_instr(6'h0D, 6'h00, 1'b0, 0, 0);
        opcode = 6'h3F;
        @(negedge clk); memAck = 1'b1; #1;
        @(negedge clk); memAck = 1'b0; #1;
        @(negedge clk); #1;
        check_val("ill_op_flags", {illegalOp, busErr}, 2'b10);
        check_val("ill_op_instRet", instRet, 32'd1);
        check_val("ill_op_cycleCnt", cycleCnt, 32'd6);
        check_val("ill_op_strobes", strobes, 17'd0);
        do_reset();
        opcode = 6'h00; funcode = 6'h07;
        @(negedge clk); memAck = 1'b1; #1;
        @(negedge clk); memAck = 1'b0; #1;
        @(negedge clk); #1;
        check_val("ill_fn_flags", {illegalOp, busErr}, 2'b10);
        check_val("ill_fn_instRet", instRet, 32'd0);
        check_val("ill_fn_cycleCnt", cycleCnt, 32'd2);

        // Reset pulsed during a store wait.
        do_reset();
        opcode = 6'h2B; funcode = 6'h00;
        @(negedge clk); memAck = 1'b1; #1;
        @(negedge clk); memAck = 1'b0; #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        check_val("memwr_req", {memReq, memWrite, iorD}, 3'b111);
        #1 rst = 1'b0;
        #1;
        check_val("abort_strobes", strobes, 17'd0);
        check_val("abort_counters", {cycleCnt, instRet}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk); #1;
        check_val("abort_fetch", {memReq, iorD, memWrite}, 3'b100);
        check_val("abort_cnt_after", {cycleCnt, instRet}, 64'd0);

        // CNT_W=4 instance: 17 beq with single-cycle fetch ack, 51 cycles.
        equal4 = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1 rst4 = 1'b1;
        repeat (51) @(posedge clk);
        @(negedge clk); #1;
        check_val("wrap_instRet", instRet4, 4'd1);
        check_val("wrap_cycleCnt", cycleCnt4, 4'(51 % 16));
        check_val("wrap_fetch", strobes4, 17'b1_0_0_1_1_00_0_0_0_0_01_000_0);
        check_val("wrap_flags", {busErr4, illegalOp4}, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
